// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button levels in, debounced levels and event pulses out.
interface button_conditioner_if #(
   parameter int N_CH = 5
);
   logic [N_CH-1:0] noisy_in;
   logic [N_CH-1:0] clean_out;
   logic [N_CH-1:0] rise_out;
   logic [N_CH-1:0] fall_out;
   logic [N_CH-1:0] press_out;

   modport master (
      output noisy_in,
      input  clean_out,
      input  rise_out,
      input  fall_out,
      input  press_out
   );

   modport slave (
      input  noisy_in,
      output clean_out,
      output rise_out,
      output fall_out,
      output press_out
   );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel synchroniser, counter debouncer, edge pulses and optional auto-repeat.
// Auto-repeat FSMs are compiled in only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
   parameter int N_CH          = 5,
   parameter int COUNT_MAX     = 1000000,
   parameter int REPEAT_DELAY  = 12500000,
   parameter int REPEAT_PERIOD = 3125000
) (
   input logic                clock,
   input logic                reset,
   button_conditioner_if.slave bus
);
   localparam int CW = $clog2(COUNT_MAX + 1);

   logic [N_CH-1:0] sync1_r;
   logic [N_CH-1:0] sync2_r;
   logic [N_CH-1:0] sample_r;
   logic [N_CH-1:0] clean_r;
   logic [N_CH-1:0] rise_r;
   logic [N_CH-1:0] fall_r;
   logic [N_CH-1:0] press_r;
   logic [CW-1:0]   count_r [N_CH];

   logic [N_CH-1:0] sample_s;
   logic [N_CH-1:0] clean_s;
   logic [N_CH-1:0] rise_s;
   logic [N_CH-1:0] fall_s;
   logic [N_CH-1:0] press_s;
   logic [CW-1:0]   count_s [N_CH];

   // Debounce next-state: a sample change restarts the count, a full count commits it.
   always_comb begin
      sample_s = sample_r;
      clean_s  = clean_r;
      for (int i = 0; i < N_CH; i++) begin
         count_s[i] = count_r[i];
         if (sync2_r[i] != sample_r[i]) begin
            sample_s[i] = sync2_r[i];
            count_s[i]  = {CW{1'b0}};
         end else if (count_r[i] == CW'(COUNT_MAX)) begin
            clean_s[i] = sample_r[i];
         end else begin
            count_s[i] = count_r[i] + CW'(1);
         end
      end
      rise_s = clean_s & ~clean_r;
      fall_s = ~clean_s & clean_r;
   end

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rstate_t;

   rstate_t         state_r  [N_CH];
   rstate_t         state_s  [N_CH];
   logic [RW-1:0]   rcount_r [N_CH];
   logic [RW-1:0]   rcount_s [N_CH];
   logic [N_CH-1:0] fire_s;

   // Repeat FSM next-state; a low clean level overrides everything, so a fall beats a due repeat.
   always_comb begin
      fire_s = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         state_s[i]  = state_r[i];
         rcount_s[i] = rcount_r[i];
         if (!clean_s[i]) begin
            state_s[i]  = IDLE;
            rcount_s[i] = {RW{1'b0}};
         end else if (rise_s[i]) begin
            state_s[i]  = DELAY;
            rcount_s[i] = {RW{1'b0}};
         end else begin
            case (state_r[i])
               IDLE: begin
                  state_s[i] = IDLE;
               end
               DELAY: begin
                  if (rcount_r[i] == RW'(REPEAT_DELAY - 1)) begin
                     fire_s[i]   = 1'b1;
                     rcount_s[i] = {RW{1'b0}};
                     state_s[i]  = REPEAT;
                  end else begin
                     rcount_s[i] = rcount_r[i] + RW'(1);
                  end
               end
               REPEAT: begin
                  if (rcount_r[i] == RW'(REPEAT_PERIOD - 1)) begin
                     fire_s[i]   = 1'b1;
                     rcount_s[i] = {RW{1'b0}};
                  end else begin
                     rcount_s[i] = rcount_r[i] + RW'(1);
                  end
               end
               default: begin
                  state_s[i]  = IDLE;
                  rcount_s[i] = {RW{1'b0}};
               end
            endcase
         end
      end
      press_s = rise_s | fire_s;
   end

   // Repeat FSM state and counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            state_r[i]  <= IDLE;
            rcount_r[i] <= {RW{1'b0}};
         end
      end else begin
         state_r  <= state_s;
         rcount_r <= rcount_s;
      end
   end
`else
   // Without auto-repeat every press event is just the rising edge.
   always_comb begin
      press_s = rise_s;
   end
`endif

   // Synchroniser, debouncer and output registers; reset preloads the live levels so no edge follows.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_r  <= bus.noisy_in;
         sync2_r  <= bus.noisy_in;
         sample_r <= bus.noisy_in;
         clean_r  <= bus.noisy_in;
         rise_r   <= {N_CH{1'b0}};
         fall_r   <= {N_CH{1'b0}};
         press_r  <= {N_CH{1'b0}};
         for (int i = 0; i < N_CH; i++) begin
            count_r[i] <= {CW{1'b0}};
         end
      end else begin
         sync1_r  <= bus.noisy_in;
         sync2_r  <= sync1_r;
         sample_r <= sample_s;
         clean_r  <= clean_s;
         rise_r   <= rise_s;
         fall_r   <= fall_s;
         press_r  <= press_s;
         count_r  <= count_s;
      end
   end

   assign bus.clean_out = clean_r;
   assign bus.rise_out  = rise_r;
   assign bus.fall_out  = fall_r;
   assign bus.press_out = press_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events are queued at stimulus time
// and matched by an output monitor; tasks also check clean levels inline.
module tb_button_conditioner;
   localparam int N_CH          = 5;
   localparam int COUNT_MAX     = 4;
   localparam int REPEAT_DELAY  = 10;
   localparam int REPEAT_PERIOD = 3;
   localparam int LAT           = COUNT_MAX + 4;
`ifdef BUTTON_AUTOREPEAT_EN
   localparam bit AUTO_REP = 1'b1;
`else
   localparam bit AUTO_REP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   tests_run = 0;
   int   failed = 0;
   int   exp_q[$];

   button_conditioner_if #(.N_CH(N_CH)) bus ();

   button_conditioner #(
      .N_CH(N_CH),
      .COUNT_MAX(COUNT_MAX),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Event key: cycle, channel, kind (0 rise, 1 fall, 2 press); sorting keys orders events like the monitor.
   function automatic int ev_key(input int c, input int ch, input int k);
      return c * 64 + ch * 4 + k;
   endfunction

   function automatic void push_ev(input int c, input int ch, input int k);
      exp_q.push_back(ev_key(c, ch, k));
      exp_q.sort();
   endfunction

   // Expected events for one press of channel ch, clean rising at rise_c and falling at fall_c.
   function automatic void expect_press(input int ch, input int rise_c, input int fall_c);
      int nxt;
      push_ev(rise_c, ch, 0);
      push_ev(rise_c, ch, 2);
      push_ev(fall_c, ch, 1);
      if (AUTO_REP) begin
         nxt = rise_c + REPEAT_DELAY;
         while (nxt < fall_c) begin
            push_ev(nxt, ch, 2);
            nxt = nxt + REPEAT_PERIOD;
         end
      end
   endfunction

   // Output monitor: every observed pulse must be the next expected event.
   always @(negedge clock) begin
      logic pulse;
      int   key;
      int   e;
      for (int ch = 0; ch < N_CH; ch++) begin
         for (int k = 0; k < 3; k++) begin
            pulse = (k == 0) ? bus.rise_out[ch] : (k == 1) ? bus.fall_out[ch] : bus.press_out[ch];
            if (pulse !== 1'b0) begin
               key = ev_key(cyc, ch, k);
               tests_run++;
               if (exp_q.size() == 0) begin
                  failed++;
                  $display("FAIL event: got cyc=%0d ch=%0d kind=%0d, expected no event", cyc, ch, k);
               end else begin
                  e = exp_q.pop_front();
                  if (e !== key) begin
                     failed++;
                     $display("FAIL event: got cyc=%0d ch=%0d kind=%0d, expected cyc=%0d ch=%0d kind=%0d",
                              cyc, ch, k, e / 64, (e % 64) / 4, e % 4);
                  end
               end
            end
         end
      end
   end

   task automatic apply_reset(input logic [N_CH-1:0] val);
      @(negedge clock);
      reset = 1'b1;
      bus.noisy_in = val;
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      @(negedge clock);
      reset = 1'b1;
      bus.noisy_in = 5'b00000;
      repeat (2) @(negedge clock);
      tests_run++;
      if (bus.clean_out !== 5'b00000) begin
         failed++;
         $display("FAIL reset_clean0: got %b, expected %b", bus.clean_out, 5'b00000);
      end
      tests_run++;
      if ({bus.rise_out, bus.fall_out, bus.press_out} !== 15'd0) begin
         failed++;
         $display("FAIL reset_pulses: got %b, expected 0", {bus.rise_out, bus.fall_out, bus.press_out});
      end
      bus.noisy_in = 5'b10101;
      repeat (2) @(negedge clock);
      tests_run++;
      if (bus.clean_out !== 5'b10101) begin
         failed++;
         $display("FAIL reset_load: got %b, expected %b", bus.clean_out, 5'b10101);
      end
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if ((bus.rise_out | bus.press_out) !== 5'b00000) n++;
      end
      tests_run++;
      if (n !== 0) begin
         failed++;
         $display("FAIL reset_no_pulse: got %0d pulse cycles, expected 0", n);
      end
      tests_run++;
      if (bus.clean_out !== 5'b10101) begin
         failed++;
         $display("FAIL reset_hold: got %b, expected %b", bus.clean_out, 5'b10101);
      end
   endtask

   task automatic test_debounce;
      int t0;
      apply_reset(5'b00000);
      @(negedge clock);
      t0 = cyc;
      bus.noisy_in = 5'b00001;
      expect_press(0, t0 + LAT, t0 + 9 + LAT);
      repeat (LAT - 1) @(negedge clock);
      tests_run++;
      if (bus.clean_out[0] !== 1'b0) begin
         failed++;
         $display("FAIL debounce_early: got %b at cyc %0d, expected 0", bus.clean_out[0], cyc - t0);
      end
      @(negedge clock);
      tests_run++;
      if ({bus.clean_out[0], bus.rise_out[0], bus.press_out[0]} !== 3'b111) begin
         failed++;
         $display("FAIL debounce_edge: got clean/rise/press=%b, expected 111",
                  {bus.clean_out[0], bus.rise_out[0], bus.press_out[0]});
      end
      @(negedge clock);
      bus.noisy_in = 5'b00000;
      repeat (25) @(negedge clock);
      tests_run++;
      if (bus.clean_out !== 5'b00000 || exp_q.size() !== 0) begin
         failed++;
         $display("FAIL debounce_end: got clean=%b pending=%0d, expected 00000 and 0", bus.clean_out, exp_q.size());
      end
   endtask

   task automatic test_glitch;
      int t0;
      apply_reset(5'b00000);
      for (int len = 3; len <= 4; len++) begin
         @(negedge clock);
         bus.noisy_in = 5'b00010;
         repeat (len) @(negedge clock);
         bus.noisy_in = 5'b00000;
         repeat (15) @(negedge clock);
         tests_run++;
         if (bus.clean_out !== 5'b00000) begin
            failed++;
            $display("FAIL glitch_%0d: got %b, expected 00000", len, bus.clean_out);
         end
      end
      @(negedge clock);
      t0 = cyc;
      bus.noisy_in = 5'b00010;
      expect_press(1, t0 + LAT, t0 + 6 + LAT);
      repeat (6) @(negedge clock);
      bus.noisy_in = 5'b00000;
      repeat (20) @(negedge clock);
      tests_run++;
      if (bus.clean_out !== 5'b00000 || exp_q.size() !== 0) begin
         failed++;
         $display("FAIL glitch_long: got clean=%b pending=%0d, expected 00000 and 0", bus.clean_out, exp_q.size());
      end
   endtask

   task automatic test_autorepeat(input int hold, input int exp_presses);
      int t0;
      int n;
      apply_reset(5'b00000);
      @(negedge clock);
      t0 = cyc;
      bus.noisy_in = 5'b00100;
      expect_press(2, t0 + LAT, t0 + hold + LAT);
      n = 0;
      for (int i = 1; i <= hold + 25; i++) begin
         @(negedge clock);
         if (i == hold) bus.noisy_in = 5'b00000;
         if (bus.press_out[2] === 1'b1) n++;
      end
      tests_run++;
      if (n !== exp_presses) begin
         failed++;
         $display("FAIL repeat_count_hold%0d: got %0d presses, expected %0d", hold, n, exp_presses);
      end
      tests_run++;
      if (exp_q.size() !== 0) begin
         failed++;
         $display("FAIL repeat_pending_hold%0d: got %0d pending, expected 0", hold, exp_q.size());
      end
   endtask

   task automatic test_multi;
      int t0;
      apply_reset(5'b00000);
      @(negedge clock);
      t0 = cyc;
      bus.noisy_in = 5'b01001;
      expect_press(0, t0 + LAT, t0 + 20 + LAT);
      expect_press(3, t0 + 4 + LAT, t0 + 20 + LAT);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (i == 2) bus.noisy_in = 5'b00001;
         if (i == 4) bus.noisy_in = 5'b01001;
         if (i == 20) bus.noisy_in = 5'b00000;
         if (i == LAT || i == LAT + 3) begin
            tests_run++;
            if (bus.clean_out !== 5'b00001) begin
               failed++;
               $display("FAIL multi_ch0_only_at_%0d: got %b, expected 00001", i, bus.clean_out);
            end
         end
         if (i == LAT + 4) begin
            tests_run++;
            if (bus.clean_out !== 5'b01001) begin
               failed++;
               $display("FAIL multi_both: got %b, expected 01001", bus.clean_out);
            end
         end
      end
      tests_run++;
      if (exp_q.size() !== 0) begin
         failed++;
         $display("FAIL multi_pending: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_abort;
      int t0;
      apply_reset(5'b00000);
      @(negedge clock);
      bus.noisy_in = 5'b00010;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      tests_run++;
      if (bus.clean_out !== 5'b00010) begin
         failed++;
         $display("FAIL abort_debounce: got %b, expected 00010", bus.clean_out);
      end
      apply_reset(5'b00000);
      @(negedge clock);
      t0 = cyc;
      bus.noisy_in = 5'b00100;
      push_ev(t0 + LAT, 2, 0);
      push_ev(t0 + LAT, 2, 2);
      if (AUTO_REP) push_ev(t0 + LAT + REPEAT_DELAY, 2, 2);
      repeat (20) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      tests_run++;
      if (bus.clean_out !== 5'b00100 || exp_q.size() !== 0) begin
         failed++;
         $display("FAIL abort_repeat: got clean=%b pending=%0d, expected 00100 and 0", bus.clean_out, exp_q.size());
      end
   endtask

   initial begin
      bus.noisy_in = 5'b00000;
      test_reset();
      test_debounce();
      test_glitch();
      test_autorepeat(40, AUTO_REP ? 11 : 1);
      test_autorepeat(13, AUTO_REP ? 2 : 1);
      test_multi();
      test_reset_abort();
      apply_reset(5'b00000);
      repeat (5) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 5, number of independent button channels (1..16).
REQ-002 Parameter COUNT_MAX, default 1000000, stable-sample count required before clean changes (>=1).
REQ-003 Parameter REPEAT_DELAY, default 12500000, cycles from press to first auto-repeat pulse (>=2).
REQ-004 Parameter REPEAT_PERIOD, default 3125000, cycles between subsequent auto-repeat pulses (>=2).
REQ-005 clock  input  1  system clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 noisy_in  input  N_CH  raw asynchronous button levels.
REQ-008 clean_out  output  N_CH  debounced levels.
REQ-009 rise_out  output  N_CH  one-cycle pulse on clean 0->1.
REQ-010 fall_out  output  N_CH  one-cycle pulse on clean 1->0.
REQ-011 press_out  output  N_CH  one-cycle press/auto-repeat event pulse.

Function
REQ-012 Each channel SHALL pass noisy_in through a two-flop synchroniser before debouncing; channels SHALL be fully independent.
REQ-013 Debounce per channel: sample register and counter of width $clog2(COUNT_MAX+1); synced level != sample -> sample <= synced, count <= 0; else count == COUNT_MAX -> clean <= sample, count held; else count <= count+1.
REQ-014 A level change stable at the synchroniser output SHALL appear on clean_out exactly COUNT_MAX+3 clock edges after the first edge that registers it in synchroniser stage 1.
REQ-015 Any pulse on noisy_in shorter than COUNT_MAX+1 cycles at the synchroniser output SHALL NOT change clean_out.
REQ-016 rise_out[i] SHALL be high for exactly the one cycle in which clean_out[i] first reads 1 after reading 0; fall_out[i] likewise for 1->0; both registered, same cycle as the clean_out change.
REQ-017 Per-channel repeat FSM states IDLE, DELAY, REPEAT with counter rcount; IDLE -> DELAY on rise (rcount <= 0).
REQ-018 DELAY: rcount increments each cycle; at rcount == REPEAT_DELAY-1 -> pulse press_out, rcount <= 0, enter REPEAT.
REQ-019 REPEAT: rcount increments; at rcount == REPEAT_PERIOD-1 -> pulse press_out, rcount <= 0, stay.
REQ-020 clean_out[i] == 0 in any state SHALL force IDLE the next edge, with no further repeat pulse, including in a cycle where a repeat pulse would fire (fall wins).
REQ-021 press_out[i] SHALL pulse in the same cycle as rise_out[i]; pulse spacing: first repeat REPEAT_DELAY cycles after rise, then every REPEAT_PERIOD cycles while held.

Reset
REQ-022 While reset is high: synchroniser stages, sample and clean_out SHALL load noisy_in; counters 0; FSMs IDLE; rise_out, fall_out, press_out 0.
REQ-023 Reset asserted mid-debounce or mid-repeat SHALL abort the operation, with no rise/fall/press pulse in the cycle after reset deasserts.
REQ-024 A button held through reset SHALL NOT generate rise_out or press_out after release of reset.

Configuration
REQ-025 Macro BUTTON_AUTOREPEAT_EN: defined -> repeat FSMs per REQ-017..REQ-021 compiled in.
REQ-026 BUTTON_AUTOREPEAT_EN undefined -> no repeat FSMs or counters; press_out SHALL equal rise_out; REPEAT_DELAY/REPEAT_PERIOD ignored.

Verification (N_CH=5, COUNT_MAX=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 noisy_in[0] 0->1 held -> clean_out[0] high 7 edges later; rise_out[0] and press_out[0] high one cycle at that edge.
REQ-028 noisy_in[1] high for 3 cycles then low -> clean_out[1], rise_out[1] and fall_out[1] stay 0.
REQ-029 Macro defined, noisy_in[2] held 40 cycles -> press_out[2] pulses at rise, rise+10, +13, +16, ... until clean falls; fall_out[2] one pulse.
REQ-030 Macro undefined, same stimulus -> exactly one press_out[2] pulse, coincident with rise_out[2].
REQ-031 noisy_in=5'b10101 during reset, reset released -> clean_out=5'b10101, no rise/press pulses for 20 cycles.
REQ-032 Channels 0 and 3 pressed on the same cycle, channel 3 bouncing (1,0,1 every 2 cycles) then stable -> channel 0 timing unaffected, channel 3 rises 7 edges after its last bounce.
